// File: rtl/integer_sqrt_pkg.sv
// Shared definitions for the sequential integer square-root unit.
//   state_t         : controller states (IDLE, BUSY, DONE)
//   root_w()        : root width, WIDTH/2
//   bits_per_cycle(): root bits resolved per clock, ceil((WIDTH/2)/CYCLES)
//   cnt_w()         : cycle counter width, clog2(CYCLES+1)
package integer_sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int root_w(input int width);
        return width / 2;
    endfunction

    function automatic int bits_per_cycle(input int width, input int cycles);
        return (width / 2 + cycles - 1) / cycles;
    endfunction

    function automatic int cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/integer_sqrt_seq_sqrt_digit_step.sv
// One radix-2 restoring square-root step (purely combinational).
//   rem       : running remainder, ROOT_W+2 bits (upper two bits are always 0 here)
//   root      : partial root so far
//   pair      : next two radicand bits, MSB pair first
//   next_rem  : remainder after this step
//   next_root : partial root with one more bit appended
module sqrt_digit_step #(
    parameter int ROOT_W = 32
) (
    input  logic [ROOT_W+1:0] rem,
    input  logic [ROOT_W-1:0] root,
    input  logic [1:0]        pair,
    output logic [ROOT_W+1:0] next_rem,
    output logic [ROOT_W-1:0] next_root
);

    logic [ROOT_W+1:0] trial;
    logic [ROOT_W+1:0] sub;
    logic              fits;
    logic              unused_hi;

    // Before any step the remainder is <= 2*root < 2^ROOT_W, so shifting in
    // two bits never needs more than ROOT_W+2 bits; the top two are dropped.
    assign trial     = {rem[ROOT_W-1:0], pair};
    // The incoming root has at most ROOT_W-1 significant bits, so (root<<2)|1
    // fits in ROOT_W+2 bits.
    assign sub       = {root, 2'b01};
    assign fits      = (trial >= sub);
    assign next_rem  = fits ? (trial - sub) : trial;
    assign next_root = {root[ROOT_W-2:0], fits};
    assign unused_hi = ^rem[ROOT_W+1:ROOT_W];

endmodule

// File: rtl/integer_sqrt_seq.sv
// Multi-cycle unsigned integer square root: quotient = floor(sqrt(d)),
// remainder = d - quotient^2. Restoring recurrence, B root bits per clock,
// fixed latency of CYCLES clocks from operand capture to ready.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   stall     : 1 = hold/abort, 0 = run
//   d         : unsigned radicand, captured on IDLE -> BUSY
//   quotient  : floor(sqrt(d)), zero-extended
//   remainder : d - quotient^2, zero-extended
//   ready     : result valid (sticky until stall)
module integer_sqrt_seq
    import integer_sqrt_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int CYCLES = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready
);

    localparam int ROOT_W = root_w(WIDTH);
    localparam int B      = bits_per_cycle(WIDTH, CYCLES);
    localparam int CW     = cnt_w(CYCLES);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  rad;   // radicand, shifted left two bits per resolved root bit
    logic [ROOT_W+1:0] rem;
    logic [ROOT_W-1:0] root;

    // Step chain: element 0 is the registered state, element B the next state.
    logic [B:0][WIDTH-1:0]    rad_c;
    logic [B:0][ROOT_W+1:0]   rem_c;
    logic [B:0][ROOT_W-1:0]   root_c;
    logic [B-1:0][ROOT_W+1:0] step_rem;
    logic [B-1:0][ROOT_W-1:0] step_root;
    logic [B-1:0]             act;

    assign rad_c[0]  = rad;
    assign rem_c[0]  = rem;
    assign root_c[0] = root;

    for (genvar k = 0; k < B; k++) begin : g_step
        // Once all ROOT_W bits are resolved the remaining steps pass through,
        // which also covers ROOT_W not being a multiple of B and the idle
        // cycles that pad latency out to CYCLES.
        assign act[k] = ((int'(cnt) * B + k) < ROOT_W);

        sqrt_digit_step #(.ROOT_W(ROOT_W)) u_step (
            .rem       (rem_c[k]),
            .root      (root_c[k]),
            .pair      (rad_c[k][WIDTH-1 -: 2]),
            .next_rem  (step_rem[k]),
            .next_root (step_root[k])
        );

        assign rem_c[k+1]  = act[k] ? step_rem[k]  : rem_c[k];
        assign root_c[k+1] = act[k] ? step_root[k] : root_c[k];
        assign rad_c[k+1]  = act[k] ? {rad_c[k][WIDTH-3:0], 2'b00} : rad_c[k];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rad       <= '0;
            rem       <= '0;
            root      <= '0;
            quotient  <= '0;
            remainder <= '0;
            ready     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!stall) begin
                        rad   <= d;
                        rem   <= '0;
                        root  <= '0;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (stall) begin
                        // Abort: outputs untouched, ready already low.
                        state <= IDLE;
                    end else begin
                        rad  <= rad_c[B];
                        rem  <= rem_c[B];
                        root <= root_c[B];
                        cnt  <= cnt + CW'(1);
                        if (cnt == CW'(CYCLES - 1)) begin
                            quotient  <= WIDTH'(root_c[B]);
                            remainder <= WIDTH'(rem_c[B]);
                            ready     <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (stall) begin
                        ready <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_integer_sqrt_seq.sv
// Self-checking bench for integer_sqrt_seq: directed cases, abort/reset
// behaviour and randomized radicands against a binary-search reference.
module tb_integer_sqrt_seq;

    localparam int MC = 28;

    logic        clk;
    logic        rst, stall;
    logic [63:0] d, q, r;
    logic        rdy;

    logic        rst_a, stall_a;
    logic [63:0] da64;
    logic [15:0] da16;
    logic [63:0] q1, r1, q2, r2;
    logic [15:0] q3, r3, q4, r4;
    logic        rdy1, rdy2, rdy3, rdy4;

    int tests = 0;
    int fails = 0;

    integer_sqrt_seq #(.WIDTH(64), .CYCLES(MC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .d(d),
        .quotient(q), .remainder(r), .ready(rdy));

    integer_sqrt_seq #(.WIDTH(64), .CYCLES(1)) dut_a1 (
        .clk(clk), .rst(rst_a), .stall(stall_a), .d(da64),
        .quotient(q1), .remainder(r1), .ready(rdy1));

    integer_sqrt_seq #(.WIDTH(64), .CYCLES(5)) dut_a2 (
        .clk(clk), .rst(rst_a), .stall(stall_a), .d(da64),
        .quotient(q2), .remainder(r2), .ready(rdy2));

    integer_sqrt_seq #(.WIDTH(16), .CYCLES(1)) dut_a3 (
        .clk(clk), .rst(rst_a), .stall(stall_a), .d(da16),
        .quotient(q3), .remainder(r3), .ready(rdy3));

    integer_sqrt_seq #(.WIDTH(16), .CYCLES(5)) dut_a4 (
        .clk(clk), .rst(rst_a), .stall(stall_a), .d(da16),
        .quotient(q4), .remainder(r4), .ready(rdy4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Largest x with x*x <= v, by bisection on wide arithmetic.
    function automatic logic [63:0] isqrt(input logic [63:0] v);
        logic [127:0] lo, hi, mid;
        lo = '0;
        hi = 128'd1 << 32;
        while (hi - lo > 128'd1) begin
            mid = (lo + hi) >> 1;
            if (mid * mid <= {64'd0, v}) lo = mid;
            else hi = mid;
        end
        return lo[63:0];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a computation on the main unit and check exact latency and result.
    task automatic run_main(input logic [63:0] dv, input string tag);
        logic [63:0] eq;
        eq = isqrt(dv);
        @(negedge clk);
        d = dv;
        stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        d = ~dv;
        for (int c = 1; c <= MC; c++) begin
            @(posedge clk);
            #1;
            chk({tag, "_rdy"}, 128'(rdy), 128'(c == MC));
        end
        chk({tag, "_q"}, 128'(q), 128'(eq));
        chk({tag, "_r"}, 128'(r), 128'(dv - eq * eq));
    endtask

    task automatic stop_main();
        @(negedge clk);
        stall = 1'b1;
        @(posedge clk);
        #1;
        chk("stop_rdy", 128'(rdy), 128'(0));
    endtask

    task automatic run_aux(input logic [63:0] v64, input logic [15:0] v16);
        logic [63:0] e64, e16;
        e64 = isqrt(v64);
        e16 = isqrt({48'd0, v16});
        @(negedge clk);
        da64 = v64;
        da16 = v16;
        stall_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        da64 = ~v64;
        da16 = ~v16;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            chk("a1_rdy", 128'(rdy1), 128'(c >= 1));
            chk("a2_rdy", 128'(rdy2), 128'(c >= 5));
            chk("a3_rdy", 128'(rdy3), 128'(c >= 1));
            chk("a4_rdy", 128'(rdy4), 128'(c >= 5));
        end
        chk("a1_q", 128'(q1), 128'(e64));
        chk("a1_r", 128'(r1), 128'(v64 - e64 * e64));
        chk("a2_q", 128'(q2), 128'(e64));
        chk("a2_r", 128'(r2), 128'(v64 - e64 * e64));
        chk("a3_q", 128'(q3), 128'(e16));
        chk("a3_r", 128'(r3), 128'({48'd0, v16} - e16 * e16));
        chk("a4_q", 128'(q4), 128'(e16));
        chk("a4_r", 128'(r4), 128'({48'd0, v16} - e16 * e16));
        @(negedge clk);
        stall_a = 1'b1;
        @(posedge clk);
        #1;
        chk("a_stop_rdy", 128'({rdy1, rdy2, rdy3, rdy4}), 128'(0));
    endtask

    initial begin
        logic [63:0] pq, pr, v, eq;
        rst = 1'b1; stall = 1'b1; d = '0;
        rst_a = 1'b1; stall_a = 1'b1; da64 = '0; da16 = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", 128'(q), 128'(0));
        chk("rst_r", 128'(r), 128'(0));
        chk("rst_rdy", 128'(rdy), 128'(0));
        chk("rst_a_rdy", 128'({rdy1, rdy2, rdy3, rdy4}), 128'(0));

        @(negedge clk);
        rst = 1'b0;
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("idle_q", 128'(q), 128'(0));
            chk("idle_r", 128'(r), 128'(0));
            chk("idle_rdy", 128'(rdy), 128'(0));
        end

        run_main(64'h6400000000000001, "tp1");
        chk("tp1_q_const", 128'(q), 128'(64'd2684354560));
        chk("tp1_r_const", 128'(r), 128'(64'd1));
        // Stay in DONE with stall low; new d must not restart.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d = {$urandom(), $urandom()};
            @(posedge clk);
            #1;
            chk("hold_rdy", 128'(rdy), 128'(1));
            chk("hold_q", 128'(q), 128'(64'd2684354560));
            chk("hold_r", 128'(r), 128'(64'd1));
        end
        stop_main();
        chk("stop_q_kept", 128'(q), 128'(64'd2684354560));

        run_main(64'h34B69DA358B68, "tp2");
        stop_main();

        // Abort on the 10th BUSY cycle: outputs keep the previous result.
        pq = q;
        pr = r;
        @(negedge clk);
        d = 64'h0123456789ABCDEF;
        stall = 1'b0;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        stall = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_rdy", 128'(rdy), 128'(0));
        chk("abort_q", 128'(q), 128'(pq));
        chk("abort_r", 128'(r), 128'(pr));
        for (int i = 0; i < MC + 4; i++) begin
            @(posedge clk);
            #1;
            chk("abort_hold_rdy", 128'(rdy), 128'(0));
        end
        run_main(64'h0123456789ABCDEF, "restart");
        stop_main();

        run_main(64'd0, "zero");
        chk("zero_q_const", 128'(q), 128'(0));
        stop_main();
        run_main(64'hFFFFFFFFFFFFFFFF, "ones");
        chk("ones_q_const", 128'(q), 128'(64'hFFFFFFFF));
        chk("ones_r_const", 128'(r), 128'(64'h1FFFFFFFE));
        stop_main();

        for (int i = 0; i < 200; i++) begin
            v = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            run_main(v, "rnd");
            eq = q;
            chk("rnd_lo", 128'(128'(eq) * 128'(eq) <= 128'(v)), 128'(1));
            chk("rnd_hi", 128'((128'(eq) + 1) * (128'(eq) + 1) > 128'(v)), 128'(1));
            stop_main();
        end

        // Reset in the middle of BUSY clears everything on the next edge.
        @(negedge clk);
        d = 64'hDEADBEEFCAFEF00D;
        stall = 1'b0;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_q", 128'(q), 128'(0));
        chk("midrst_r", 128'(r), 128'(0));
        chk("midrst_rdy", 128'(rdy), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        run_main(64'hDEADBEEFCAFEF00D, "after_rst");
        stop_main();

        run_aux(64'd0, 16'd0);
        run_aux(64'hFFFFFFFFFFFFFFFF, 16'hFFFF);
        for (int i = 0; i < 1000; i++) begin
            run_aux({$urandom(), $urandom()} >> $urandom_range(0, 63),
                    16'($urandom()) >> $urandom_range(0, 15));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/integer_sqrt_seq.md
Name: integer_sqrt_seq

Overview:
- Multi-cycle unsigned integer square-root unit: quotient = floor(sqrt(d)), remainder = d − quotient².
- Restoring digit-recurrence engine, several root bits per clock.
- Start/abort is controlled by a single active-high stall input; a sticky ready flags the result.
- Sits as an arithmetic coprocessor beside the datapath; interface drop-in for the existing integer_sqrt instances (same parameter names, same functional port order after clk/rst).

Parameters:
- WIDTH, 64, operand width in bits; must be even, ≥ 4.
- CYCLES, 28, clock cycles from operand capture to ready; 1 ≤ CYCLES ≤ WIDTH/2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  1 = hold/abort, 0 = run.
- d  input  WIDTH  unsigned radicand.
- quotient  output  WIDTH  floor(sqrt(d)), zero-extended from WIDTH/2 bits.
- remainder  output  WIDTH  d − quotient², always ≤ 2·quotient, zero-extended.
- ready  output  1  result valid.

Behaviour:
- One clock, synchronous active-high reset.
- Reset: state IDLE, quotient = 0, remainder = 0, ready = 0, cycle counter = 0. Reset wins over all other inputs.
- Bits per cycle B = ceil((WIDTH/2)/CYCLES); defaults give B = 2.
- The engine finishes all WIDTH/2 root bits within ceil((WIDTH/2)/B) cycles. It then idles internally until the counter reaches CYCLES, so latency is always exactly CYCLES.
- States:
  - IDLE: if stall = 0 at an edge, capture d into an internal register, clear partial root and remainder, set counter = 0, go to BUSY. If stall = 1, stay in IDLE.
  - BUSY: each edge processes B bits, MSB pair first (restoring: trial = (rem<<2)|next two radicand bits; subtract (root<<2)|1 if non-negative), and increments the counter. When the counter reaches CYCLES, write quotient/remainder and set ready = 1 on that same edge, then go to DONE. stall = 1 in BUSY aborts to IDLE; outputs keep their previous values and ready stays 0.
  - DONE: hold outputs, ready = 1. stall = 1 → IDLE with ready cleared on that edge; quotient/remainder keep their values. stall = 0 → remain in DONE; no restart even if d changes.
- Timing: if stall is sampled low in IDLE at edge E0, ready is 1 after edge E0+CYCLES.
- Changes on d after capture are ignored until the next IDLE→BUSY transition.
- The internal remainder register is WIDTH/2+2 bits to avoid overflow; outputs are zero-extended.
- d = 0 → quotient 0, remainder 0. d = 2^WIDTH−1 → quotient 2^(WIDTH/2)−1, remainder 2^(WIDTH/2+1)−2.
- stall held low continuously: exactly one computation, then the block stays in DONE.

Decomposition:
- Package integer_sqrt_pkg: state enum (IDLE, BUSY, DONE); localparams ROOT_W = WIDTH/2, B, and counter width = clog2(CYCLES+1) as functions of the parameters.
- One sub-module, sqrt_digit_step: combinational single radix-2 restoring step (in: rem, root, next 2 radicand bits; out: new rem, new root). Instantiated B times in a chain.

Test Plan:
- Reset with stall = 1 → quotient 0, remainder 0, ready 0; stays so while stall = 1.
- d = 0x6400000000000001, stall dropped → ready exactly 28 cycles after capture; quotient 2684354560, remainder 1; holds while stall = 0.
- Raise stall, d = 0x34B69DA358B68, drop stall → ready clears on the stall edge; 28 cycles later quotient 30452305, remainder 54910407.
- Raise stall at cycle 10 of BUSY → ready never asserts; quotient/remainder keep their prior values; restart then yields the correct result.
- d = 0 → quotient 0, remainder 0. d = 0xFFFFFFFFFFFFFFFF → quotient 0xFFFFFFFF, remainder 0x1FFFFFFFE.
- Random d (≥ 1000 values, WIDTH = 64 and WIDTH = 16, CYCLES = 1 and CYCLES = 5) → quotient² ≤ d < (quotient+1)² and remainder = d − quotient²; assert rst mid-BUSY → all outputs 0 on the next edge.
